// File: rtl/vending_pkg.sv
// Shared definitions for the vending controller: FSM state type and coin values in nickels.
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } state_t;

    localparam int unsigned NICKEL_V  = 1;
    localparam int unsigned DIME_V    = 2;
    localparam int unsigned QUARTER_V = 5;

endpackage

// File: rtl/vend_dispense_timer.sv
// Down-counter timing the item hold: loaded on start, done while the count sits at zero.
module vend_dispense_timer #(
    parameter int unsigned CYCLES = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic en,
    output logic done
);

    localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (start) begin
            count <= W'(CYCLES - 1);
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/param_vending_machine.sv
// Coin-operated vending controller: credit accumulation, timed dispense, nickel-per-cycle change,
// cancel/refund and coin rejection.
module param_vending_machine
    import vending_pkg::*;
#(
    parameter int unsigned PRICE           = 8,
    parameter int unsigned CREDIT_W        = 4,
    parameter int unsigned DISPENSE_CYCLES = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                nickel,
    input  logic                dime,
    input  logic                quarter,
    input  logic                cancel,
    output logic                item,
    output logic                change,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    if (PRICE < 1 || (PRICE + 5) > (1 << CREDIT_W)) begin : g_bad_price
        $error("param_vending_machine: PRICE out of range for CREDIT_W");
    end
    if (DISPENSE_CYCLES < 1) begin : g_bad_cycles
        $error("param_vending_machine: DISPENSE_CYCLES must be at least 1");
    end

    localparam logic [CREDIT_W:0] PRICE_X = (CREDIT_W + 1)'(PRICE);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                reject_q, reject_d;
    logic                timer_start, timer_done;
    logic [1:0]          coin_n;
    logic                coin_any;
    logic [2:0]          coin_val;
    logic [CREDIT_W:0]   sum;

    assign coin_n   = 2'(nickel) + 2'(dime) + 2'(quarter);
    assign coin_any = nickel | dime | quarter;
    assign coin_val = quarter ? 3'(QUARTER_V) : (dime ? 3'(DIME_V) : 3'(NICKEL_V));
    assign sum      = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_val);

    vend_dispense_timer #(
        .CYCLES(DISPENSE_CYCLES)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .start(timer_start),
        .en   (state_q == VEND),
        .done (timer_done)
    );

    always_comb begin
        state_d     = state_q;
        credit_d    = credit_q;
        reject_d    = 1'b0;
        timer_start = 1'b0;
        case (state_q)
            IDLE: begin
                // Cancel takes priority: any coin presented alongside it is bounced.
                if (cancel) begin
                    reject_d = coin_any;
                    if (credit_q != '0) state_d = CHANGE;
                end else if (coin_n > 2'd1) begin
                    reject_d = 1'b1;
                end else if (coin_any) begin
                    if (sum >= PRICE_X) begin
                        state_d     = VEND;
                        credit_d    = CREDIT_W'(sum - PRICE_X);
                        timer_start = 1'b1;
                    end else begin
                        credit_d = CREDIT_W'(sum);
                    end
                end
            end
            VEND: begin
                reject_d = coin_any;
                if (timer_done) state_d = (credit_q != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                reject_d = coin_any;
                credit_d = credit_q - CREDIT_W'(1);
                if (credit_q == CREDIT_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            credit_q <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            reject_q <= reject_d;
        end
    end

    assign item        = (state_q == VEND);
    assign change      = (state_q == CHANGE);
    assign busy        = (state_q != IDLE);
    assign coin_reject = reject_q;
    assign credit      = credit_q;

endmodule
